// File: rtl/lcd_capture.sv
// DMG LCD bus capture: synchronises the async LCD pins and emits 2-bit pixel writes at {line, column}.
// Latency: write strobe SYNC_STAGES+2 cycles after an LcdClk fall; no backpressure, writes are fire-and-forget.
module lcd_capture #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 144,
    parameter int SYNC_STAGES = 2
) (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        LcdClk,
    input  logic        LcdHsync,
    input  logic        LcdVsync,
    input  logic [1:0]  LcdData,
    output logic [15:0] WrAddress,
    output logic [1:0]  Data,
    output logic        WE,
    output logic        WrClockEn,
    output logic        FrameDone,
    output logic [7:0]  FrameCount,
    output logic        Overrun
);

    localparam logic [7:0] H_MAX  = 8'(H_ACTIVE);
    localparam logic [7:0] V_END  = 8'(V_ACTIVE);
    localparam logic [7:0] V_LAST = 8'(V_ACTIVE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLANK} state_t;

    logic [SYNC_STAGES-1:0]      r_clk_sync, r_hs_sync, r_vs_sync;
    logic [SYNC_STAGES-1:0][1:0] r_dat_sync;
    logic                        r_clk_hist, r_hs_hist, r_vs_hist;
    logic                        r_px_edge, r_hs_edge, r_vs_edge;
    logic [1:0]                  r_px_dat;

    state_t      r_state, w_state;
    logic [7:0]  r_x, w_x, r_y, w_y;
    logic        r_skip_hs, w_skip_hs;
    logic        r_ovr, w_ovr;
    logic [15:0] r_addr, w_addr;
    logic [1:0]  r_dat, w_dat;
    logic        r_we, w_we;
    logic        r_fd, w_fd;
    logic [7:0]  r_fc, w_fc;
    logic        r_wce;

    logic w_clk_s, w_hs_s, w_vs_s;
    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_hs_s  = r_hs_sync[SYNC_STAGES-1];
    assign w_vs_s  = r_vs_sync[SYNC_STAGES-1];

    // Data shares the clock's stage count so the sampled value lines up with the detected fall.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_clk_sync <= '0;
            r_hs_sync  <= '0;
            r_vs_sync  <= '0;
            r_dat_sync <= '0;
            r_clk_hist <= 1'b0;
            r_hs_hist  <= 1'b0;
            r_vs_hist  <= 1'b0;
            r_px_edge  <= 1'b0;
            r_hs_edge  <= 1'b0;
            r_vs_edge  <= 1'b0;
            r_px_dat   <= 2'd0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], LcdClk};
            r_hs_sync  <= {r_hs_sync[SYNC_STAGES-2:0], LcdHsync};
            r_vs_sync  <= {r_vs_sync[SYNC_STAGES-2:0], LcdVsync};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], LcdData};
            r_clk_hist <= w_clk_s;
            r_hs_hist  <= w_hs_s;
            r_vs_hist  <= w_vs_s;
            r_px_edge  <= r_clk_hist & ~w_clk_s;
            r_hs_edge  <= ~r_hs_hist & w_hs_s;
            r_vs_edge  <= ~r_vs_hist & w_vs_s;
            r_px_dat   <= r_dat_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state   <= S_IDLE;
            r_x       <= 8'd0;
            r_y       <= 8'd0;
            r_skip_hs <= 1'b0;
            r_ovr     <= 1'b0;
            r_addr    <= 16'd0;
            r_dat     <= 2'd0;
            r_we      <= 1'b0;
            r_fd      <= 1'b0;
            r_fc      <= 8'd0;
            r_wce     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_x       <= w_x;
            r_y       <= w_y;
            r_skip_hs <= w_skip_hs;
            r_ovr     <= w_ovr;
            r_addr    <= w_addr;
            r_dat     <= w_dat;
            r_we      <= w_we;
            r_fd      <= w_fd;
            r_fc      <= w_fc;
            r_wce     <= 1'b1;
        end
    end

    // Position updates first (vsync over hsync), then the pixel lands on the updated position.
    always_comb begin
        w_state   = r_state;
        w_x       = r_x;
        w_y       = r_y;
        w_skip_hs = r_skip_hs;
        w_ovr     = r_ovr;
        w_addr    = r_addr;
        w_dat     = r_dat;
        w_we      = 1'b0;
        w_fd      = 1'b0;
        w_fc      = r_fc;

        if (r_vs_edge) begin
            w_state   = S_ACTIVE;
            w_x       = 8'd0;
            w_y       = 8'd0;
            w_skip_hs = 1'b1;
            w_ovr     = 1'b0;
        end else if (r_hs_edge && r_state != S_IDLE) begin
            w_x = 8'd0;
            if (r_skip_hs) begin
                w_skip_hs = 1'b0;
            end else if (r_state == S_BLANK) begin
                w_ovr = 1'b1;
                w_y   = V_END;
            end else if (r_y == V_LAST) begin
                w_y     = V_END;
                w_fd    = 1'b1;
                w_fc    = r_fc + 8'd1;
                w_state = S_BLANK;
            end else begin
                w_y = r_y + 8'd1;
            end
        end

        if (r_px_edge && w_state == S_ACTIVE) begin
            if (w_x < H_MAX) begin
                w_addr = {w_y, w_x};
                w_dat  = r_px_dat;
                w_we   = 1'b1;
                w_x    = w_x + 8'd1;
            end else begin
                w_ovr = 1'b1;
            end
        end
    end

    assign WrAddress  = r_addr;
    assign Data       = r_dat;
    assign WE         = r_we;
    assign WrClockEn  = r_wce;
    assign FrameDone  = r_fd;
    assign FrameCount = r_fc;
    assign Overrun    = r_ovr;

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: behavioural position model feeds a write scoreboard checked on every WE.
module tb_lcd_capture;

    localparam int H_ACTIVE    = 160;
    localparam int V_ACTIVE    = 144;
    localparam int SYNC_STAGES = 2;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        LcdClk = 1'b0;
    logic        LcdHsync = 1'b0;
    logic        LcdVsync = 1'b0;
    logic [1:0]  LcdData = 2'd0;
    logic [15:0] WrAddress;
    logic [1:0]  Data;
    logic        WE;
    logic        WrClockEn;
    logic        FrameDone;
    logic [7:0]  FrameCount;
    logic        Overrun;

    lcd_capture #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .Clock(Clock),
        .ResetN(ResetN),
        .LcdClk(LcdClk),
        .LcdHsync(LcdHsync),
        .LcdVsync(LcdVsync),
        .LcdData(LcdData),
        .WrAddress(WrAddress),
        .Data(Data),
        .WE(WE),
        .WrClockEn(WrClockEn),
        .FrameDone(FrameDone),
        .FrameCount(FrameCount),
        .Overrun(Overrun)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int fd_cnt = 0;

    logic [17:0] sb[$];

    // model state: 0 idle, 1 active, 2 blank
    int         m_state = 0;
    logic [7:0] m_x = 8'd0;
    logic [7:0] m_y = 8'd0;
    bit         m_skip = 1'b0;
    bit         m_ovr = 1'b0;
    int         m_fc = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (WE) begin
            we_cnt++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                logic [17:0] e;
                e = sb.pop_front();
                chk("wr_addr", int'(WrAddress), int'(e[17:2]));
                chk("wr_data", int'(Data), int'(e[1:0]));
            end
        end
        if (FrameDone) fd_cnt++;
    end

    task automatic model_vs();
        m_state = 1; m_x = 0; m_y = 0; m_skip = 1; m_ovr = 0;
    endtask

    task automatic model_hs();
        if (m_state != 0) begin
            m_x = 0;
            if (m_skip) m_skip = 0;
            else if (m_state == 2) m_ovr = 1;
            else if (int'(m_y) == V_ACTIVE - 1) begin
                m_y = 8'(V_ACTIVE); m_state = 2; m_fc = (m_fc + 1) % 256;
            end else m_y = m_y + 8'd1;
        end
    endtask

    task automatic model_px(input logic [1:0] d);
        if (m_state == 1) begin
            if (int'(m_x) < H_ACTIVE) begin
                sb.push_back({m_y, m_x, d});
                m_x = m_x + 8'd1;
            end else m_ovr = 1;
        end
    endtask

    task automatic vsync();
        LcdVsync = 1'b1; model_vs();
        repeat (5) @(negedge Clock);
        LcdVsync = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    task automatic hsync();
        LcdHsync = 1'b1; model_hs();
        repeat (5) @(negedge Clock);
        LcdHsync = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    // with_hs raises hsync in the same instant as the LcdClk fall
    task automatic pixel(input logic [1:0] d, input bit meas, input bit with_hs);
        int lat;
        LcdData = d;
        LcdClk = 1'b1;
        repeat (3) @(negedge Clock);
        LcdClk = 1'b0;
        if (with_hs) begin
            LcdHsync = 1'b1;
            model_hs();
        end
        model_px(d);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clock); #1;
            if (WE && lat == 0) lat = i;
        end
        if (meas) chk("px_latency", lat, SYNC_STAGES + 2);
        @(negedge Clock);
        LcdHsync = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    initial begin
        int base;
        int seen;

        // reset state
        repeat (3) @(negedge Clock);
        chk("rst_we", int'(WE), 0);
        chk("rst_addr", int'(WrAddress), 0);
        chk("rst_data", int'(Data), 0);
        chk("rst_wce", int'(WrClockEn), 0);
        chk("rst_fd", int'(FrameDone), 0);
        chk("rst_fc", int'(FrameCount), 0);
        chk("rst_ovr", int'(Overrun), 0);
        ResetN = 1'b1;
        @(posedge Clock); #1;
        chk("wce_after_rst", int'(WrClockEn), 1);
        @(negedge Clock);

        // idle: pixels without vsync are ignored
        for (int i = 0; i < 10; i++) pixel(2'(i), 1'b0, 1'b0);
        chk("idle_we_cnt", we_cnt, 0);
        chk("idle_fc", int'(FrameCount), 0);
        chk("idle_ovr", int'(Overrun), 0);

        // one full line with latency measurement
        vsync();
        hsync();
        for (int i = 0; i < H_ACTIVE; i++) pixel(2'(i % 4), 1'b1, 1'b0);
        chk("line_we_cnt", we_cnt, H_ACTIVE);
        chk("line_sb_left", sb.size(), 0);
        chk("line_ovr", int'(Overrun), 0);

        // full frame: sparse middle lines, full last line
        vsync();
        hsync();
        pixel(2'd3, 1'b0, 1'b0);
        for (int ln = 1; ln < V_ACTIVE - 1; ln++) begin
            hsync();
            pixel(2'(ln % 4), 1'b0, 1'b0);
        end
        hsync();
        for (int i = 0; i < H_ACTIVE; i++) pixel(2'((i + 1) % 4), 1'b0, 1'b0);
        chk("frame_last_addr", int'(WrAddress), 16'h8F9F);
        chk("frame_fd_before", fd_cnt, 0);
        hsync();
        chk("frame_fd_cnt", fd_cnt, 1);
        chk("frame_fc", int'(FrameCount), m_fc);
        chk("frame_fc_one", int'(FrameCount), 1);
        base = we_cnt;
        pixel(2'd1, 1'b0, 1'b0);
        chk("blank_no_we", we_cnt, base);
        chk("blank_ovr_pre", int'(Overrun), 0);
        hsync();
        chk("blank_hs_ovr", int'(Overrun), int'(m_ovr));
        chk("blank_fd_cnt", fd_cnt, 1);
        chk("frame_sb_left", sb.size(), 0);

        // overrun: 162 pixels on one line
        vsync();
        chk("vs_clears_ovr", int'(Overrun), 0);
        hsync();
        base = we_cnt;
        for (int i = 0; i < H_ACTIVE + 2; i++) pixel(2'($urandom_range(0, 3)), 1'b0, 1'b0);
        chk("ovr_we_cnt", we_cnt - base, H_ACTIVE);
        chk("ovr_flag", int'(Overrun), 1);
        vsync();
        chk("ovr_cleared", int'(Overrun), 0);

        // simultaneous hsync and pixel on line 3
        hsync();
        for (int ln = 0; ln < 3; ln++) hsync();
        pixel(2'd2, 1'b0, 1'b0);
        pixel(2'd1, 1'b0, 1'b1);
        chk("simul_addr", int'(WrAddress), 16'h0400);
        pixel(2'd3, 1'b0, 1'b0);
        chk("simul_next_addr", int'(WrAddress), 16'h0401);
        chk("simul_sb_left", sb.size(), 0);

        // reset during a write at y=5, x=50
        vsync();
        hsync();
        for (int ln = 0; ln < 5; ln++) hsync();
        for (int i = 0; i < 50; i++) pixel(2'(i % 4), 1'b0, 1'b0);
        chk("pre_rst_addr", int'(WrAddress), 16'h0531);
        LcdData = 2'd2;
        LcdClk = 1'b1;
        repeat (3) @(negedge Clock);
        LcdClk = 1'b0;
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clock); #1;
            if (WE) begin
                seen = 1;
                break;
            end
        end
        chk("rst_write_seen", seen, 1);
        chk("rst_write_addr", int'(WrAddress), 16'h0532);
        ResetN = 1'b0;
        #1;
        chk("midrst_we", int'(WE), 0);
        chk("midrst_addr", int'(WrAddress), 0);
        chk("midrst_fc", int'(FrameCount), 0);
        m_state = 0; m_x = 0; m_y = 0; m_skip = 0; m_ovr = 0; m_fc = 0;
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        base = we_cnt;
        for (int i = 0; i < 4; i++) pixel(2'd1, 1'b0, 1'b0);
        hsync();
        pixel(2'd1, 1'b0, 1'b0);
        chk("post_rst_ignored", we_cnt, base);
        vsync();
        hsync();
        pixel(2'd2, 1'b0, 1'b0);
        chk("post_rst_we_cnt", we_cnt - base, 1);
        chk("post_rst_addr", int'(WrAddress), 0);
        chk("final_sb_left", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_capture.md
Name: lcd_capture

Overview:
- Upstream write-side stage of the frame buffer: captures the raw DMG LCD bus (pixel clock, line latch, frame start, 2-bit pixel data) and turns it into single-cycle 2-bit pixel writes at a {line, column} address.
- The LCD signals are asynchronous to the block clock. They are synchronised and edge-detected here, then a small state machine tracks frame and line position.
- Outputs connect directly to the frame buffer's write-address, write-data, write-enable and write-clock-enable inputs. The frame buffer write clock is driven by the same Clock.

Parameters:
H_ACTIVE, 160, pixels per line; pixels beyond this in a line are dropped
V_ACTIVE, 144, lines per frame; lines beyond this are dropped
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (min 2)

Ports:
Clock  in  1  system clock; all logic on rising edge
ResetN  in  1  asynchronous, active-low reset
LcdClk  in  1  LCD pixel clock (async); data valid at falling edge
LcdHsync  in  1  LCD line latch (async); rising edge = new line
LcdVsync  in  1  LCD frame start (async); rising edge = new frame
LcdData  in  2  LCD pixel data (async), sampled with LcdClk
WrAddress  out  16  {line[7:0], column[7:0]}
Data  out  2  pixel value for WrAddress
WE  out  1  one-cycle write strobe
WrClockEn  out  1  write clock enable; 1 whenever not in reset
FrameDone  out  1  one-cycle pulse when line V_ACTIVE-1 completes
FrameCount  out  8  completed frames, wraps 255->0
Overrun  out  1  sticky flag: pixel or line beyond active area seen; cleared by vsync edge

Behaviour:
- Reset (ResetN=0, async): all outputs 0, state IDLE, x=0, y=0, skip_hs=0, synchronisers cleared. WrClockEn goes 1 on the first clock after release.
- Synchronisers:
  - LcdClk, LcdHsync and LcdVsync each pass through SYNC_STAGES flip-flops plus one history flop for edge detection.
  - LcdData passes through the same stage count as LcdClk, so data and clock stay aligned.
  - An edge is detected SYNC_STAGES+1 cycles after the pin changes.
- Pixel sample: taken on a detected LcdClk falling edge, using the synchronised LcdData from that same cycle.
- Write timing: a pixel write registers WrAddress, Data and WE=1 on the cycle after the edge detect. WE is high for exactly 1 cycle. WrAddress and Data hold their values until the next write.
- States:
  - IDLE: ignore everything except the vsync edge. Pixel and hsync edges produce no write.
  - ACTIVE: y < V_ACTIVE; pixel writes are enabled.
  - BLANK: y >= V_ACTIVE; no writes; wait for the vsync edge.
- Vsync edge (any state): y=0, x=0, skip_hs=1, Overrun=0, go to ACTIVE.
- Hsync edge in ACTIVE or BLANK:
  - If skip_hs=1: clear skip_hs, x=0, y unchanged. This is the latch of line 0.
  - Otherwise: x=0, y=y+1.
  - If y goes from V_ACTIVE-1 to V_ACTIVE: pulse FrameDone for 1 cycle, FrameCount+1, go to BLANK.
  - An hsync edge in BLANK sets Overrun; y saturates at V_ACTIVE.
- Pixel edge in ACTIVE:
  - If x < H_ACTIVE: write at {y, x}, then x=x+1.
  - If x >= H_ACTIVE: no write, set Overrun; x saturates.
- Simultaneous edges, priority order: vsync > hsync > pixel.
  - A pixel edge in the same cycle as an hsync or vsync edge is applied after the position update. It writes to column 0 of the new line, and x becomes 1.
  - A simultaneous hsync and vsync behaves as vsync alone (skip_hs still set).
- Vsync mid-frame (before V_ACTIVE lines): restart at y=0. FrameDone is not pulsed and FrameCount is unchanged.
- Reset mid-write: WE drops immediately (async). The state returns to IDLE, and writing resumes only after the next vsync edge.
- Arithmetic:
  - x and y are 8 bits; the unused WrAddress bits come from these registers directly.
  - With the defaults, the maximum address is 0x8F9F (y=143, x=159).

Test Plan:
- Reset, then toggle LcdClk 10 times with no vsync -> WE never asserts; FrameCount=0, Overrun=0.
- Vsync edge, hsync edge, 160 pixels with LcdData = x mod 4 -> 160 WE pulses, addresses 0x0000..0x009F, Data cycles 0,1,2,3. Check the latency from each LcdClk falling edge to WE is SYNC_STAGES+2 cycles.
- Full frame, 144 lines x 160 pixels -> last write at 0x8F9F. FrameDone pulses once on the 144th post-skip hsync edge; FrameCount=1; state BLANK; a further pixel produces no WE.
- 162 pixels on one line -> writes to columns 0..159 only, Overrun=1. The next vsync edge clears Overrun.
- Hsync edge and pixel edge in the same synchronised cycle on line 3 -> write at 0x0400 (y=4, x=0); the next pixel writes 0x0401.
- Assert ResetN low mid-line at y=5, x=50 -> WE=0 and WrAddress=0 immediately. After release, pixels are ignored until a vsync edge; the first write after vsync+hsync is at 0x0000.
